// File: rtl/fifo_async_pkg.sv
// Shared definitions for both clock domains of the asynchronous FIFO:
// default pointer sizing and the Gray/binary conversion helpers.
package fifo_async_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 4;
  localparam int PTR_W                = DEFAULT_ADDRESS_SIZE + 1;

  // Gray to binary. The input is zero-extended to 32 bits, so callers cast the
  // result back to their own pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: each bit differs from its upper neighbour.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/two_ff_synchronizer.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus.
// Only one bit changes per source update, so per-bit capture is coherent.
module two_ff_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      q        <= '0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/r_clk_module.sv
// Read-domain control of the asynchronous FIFO.
// Advances the Gray read pointer on accepted reads, drives the RAM read
// address, synchronises the write pointer and produces registered empty and
// occupancy flags. Optional feature macro: R_ALMOST_EMPTY_EN adds
// r_almost_empty (asserted when the next level is <= AEMPTY_THRESH).
module r_clk_module
  import fifo_async_pkg::*;
#(
  parameter int MEMORY_DEPTH  = 16,
  parameter int ADDRESS_SIZE  = DEFAULT_ADDRESS_SIZE,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                    r_clk,
  input  logic                    r_rst,
  input  logic                    r_en,
  input  logic [ADDRESS_SIZE:0]   w_ptr,
  output logic [ADDRESS_SIZE:0]   r_ptr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                    r_empty,
`ifdef R_ALMOST_EMPTY_EN
  output logic                    r_almost_empty,
`endif
  output logic [ADDRESS_SIZE:0]   r_level
);

  localparam int RPTR_W = ADDRESS_SIZE + 1;

  logic [RPTR_W-1:0] rq2_wptr;
  logic [RPTR_W-1:0] rq2_wbin;
  logic [RPTR_W-1:0] r_bin;
  logic [RPTR_W-1:0] r_bnext;
  logic [RPTR_W-1:0] r_gnext;
  logic [RPTR_W-1:0] level_next;
  logic              msb_q;
  logic              sync_rst_n;
  logic              unused_cfg;

  // The synchroniser uses an active-low reset.
  assign sync_rst_n = ~r_rst;

  two_ff_synchronizer #(
    .WIDTH (RPTR_W)
  ) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (sync_rst_n),
    .d     (w_ptr),
    .q     (rq2_wptr)
  );

  // A read is accepted only while data is known to be present.
  assign r_bin      = RPTR_W'(gray2bin(32'(r_ptr)));
  assign r_bnext    = r_bin + RPTR_W'(r_en & ~r_empty);
  assign r_gnext    = RPTR_W'(bin2gray(32'(r_bnext)));
  assign rq2_wbin   = RPTR_W'(gray2bin(32'(rq2_wptr)));
  assign level_next = rq2_wbin - r_bnext;

  // Address MSB is the binary bit recovered from the top two Gray bits;
  // the lower bits are taken directly from the Gray pointer, matching the
  // write side so both ports address the same word.
  assign r_addr = {msb_q, r_ptr[ADDRESS_SIZE-2:0]};

  // Pointer, address MSB and flags all update from the next-pointer value.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_ptr   <= '0;
      msb_q   <= 1'b0;
      r_empty <= 1'b1;
      r_level <= '0;
    end else begin
      r_ptr   <= r_gnext;
      msb_q   <= r_gnext[ADDRESS_SIZE] ^ r_gnext[ADDRESS_SIZE-1];
      r_empty <= (r_gnext == rq2_wptr);
      r_level <= level_next;
    end
  end

`ifdef R_ALMOST_EMPTY_EN
  // Almost-empty tracks the same next-level value as r_level.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (level_next <= RPTR_W'(AEMPTY_THRESH));
    end
  end

  // Depth/address consistency bit; nothing consumes it.
  assign unused_cfg = (MEMORY_DEPTH != (1 << ADDRESS_SIZE));
`else
  // Depth/address consistency bit; the threshold has no function here.
  assign unused_cfg = (MEMORY_DEPTH != (1 << ADDRESS_SIZE)) | (AEMPTY_THRESH < 0);
`endif

endmodule
